// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer: serialises lb/lbu/lh/lhu/lw/sb/sh/sw into
// big-endian byte transactions on an 8-bit synchronous RAM port.
module load_store_unit #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, LAST, RESP} state_t;

    state_t                state_reg;
    logic                  write_reg;
    logic                  unsigned_reg;
    logic [1:0]            size_reg;
    logic [1:0]            idx_reg;
    logic [1:0]            last_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic [31:0]           wdata_reg;
    logic [23:0]           rbuf_reg;

    logic                  req_err;
    logic [1:0]            req_last;
    logic [1:0]            idx_next;
    logic [31:0]           load_word;
    logic [31:0]           load_ext;
    logic [7:0]            wlane [4];
    logic [7:0]            req_lane [4];

    // Byte lanes, lane 0 = bits [7:0]; lanes are emitted from lane n-1 down to 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wlane[gi]    = wdata_reg[8*gi +: 8];
            assign req_lane[gi] = req_wdata[8*gi +: 8];
        end
    endgenerate

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || ((req_addr >> ADDR_WIDTH) != 32'd0);
        case (req_size)
            2'b00:   req_last = 2'd0;
            2'b01:   req_last = 2'd1;
            default: req_last = 2'd3;
        endcase
        idx_next  = idx_reg + 2'd1;
        load_word = {rbuf_reg, mem_rdata};
        case (size_reg)
            2'b00:   load_ext = {{24{~unsigned_reg & load_word[7]}}, load_word[7:0]};
            2'b01:   load_ext = {{16{~unsigned_reg & load_word[15]}}, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            unsigned_reg <= 1'b0;
            size_reg     <= 2'b00;
            idx_reg      <= 2'd0;
            last_reg     <= 2'd0;
            base_reg     <= '0;
            wdata_reg    <= 32'd0;
            rbuf_reg     <= 24'd0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_err     <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg    <= req_write;
                        unsigned_reg <= req_unsigned;
                        size_reg     <= req_size;
                        last_reg     <= req_last;
                        idx_reg      <= 2'd0;
                        base_reg     <= req_addr[ADDR_WIDTH-1:0];
                        wdata_reg    <= req_wdata;
                        if (req_err) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            // First byte is presented straight from the request.
                            state_reg <= ACCESS;
                            mem_addr  <= req_addr[ADDR_WIDTH-1:0];
                            mem_we    <= req_write;
                            mem_wdata <= req_lane[req_last];
                        end
                    end
                end
                ACCESS: begin
                    if (idx_reg != 2'd0)
                        rbuf_reg <= load_word[23:0];
                    if (idx_reg == last_reg) begin
                        mem_we <= 1'b0;
                        if (write_reg) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'd0;
                        end else begin
                            state_reg <= LAST;
                        end
                    end else begin
                        idx_reg   <= idx_next;
                        mem_addr  <= base_reg + ADDR_WIDTH'(idx_next);
                        mem_wdata <= wlane[last_reg - idx_next];
                    end
                end
                LAST: begin
                    // Final byte arrives now; extend from the combined word directly.
                    rbuf_reg   <= load_word[23:0];
                    state_reg  <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_ext;
                end
                default: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state_reg  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte RAM and cycle-accurate checks.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  ram [0:65535];
    logic [15:0] log_addr [0:15];
    logic        log_we   [0:15];
    logic [7:0]  log_wd   [0:15];
    logic        log_busy [0:15];
    logic        log_rv   [0:15];

    int n_vec = 0;
    int n_err = 0;

    load_store_unit #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that ends RESP.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int resp_cyc, output logic [31:0] rdata,
                           output logic err, output int we_cnt);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        resp_cyc = -1; rdata = 32'hx; err = 1'bx; we_cnt = 0;
        @(negedge clk);
        chk("ready_at_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            log_addr[c] = mem_addr; log_we[c] = mem_we; log_wd[c] = mem_wdata;
            if (mem_we) we_cnt++;
            if (resp_valid) begin
                resp_cyc = c; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        @(posedge clk); #1;
        $display("txn we=%0b size=%0d uns=%0b addr=%h wdata=%h -> resp cycle %0d rdata=%h err=%0b",
                 w, sz, un, a, wd, resp_cyc, rdata, err);
    endtask

    task automatic expect_ok(input string tag, input logic w, input logic [1:0] sz,
                             input logic un, input logic [31:0] a, input logic [31:0] wd,
                             input int exp_cyc, input logic [31:0] exp_rd);
        int cyc, wec; logic [31:0] rd; logic e;
        run_req(w, sz, un, a, wd, cyc, rd, e, wec);
        chk({tag, "_cycle"}, cyc, exp_cyc);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic expect_err(input string tag, input logic [1:0] sz, input logic [31:0] a);
        int cyc, wec; logic [31:0] rd; logic e;
        run_req(1'b0, sz, 1'b0, a, 32'hDEADBEEF, cyc, rd, e, wec);
        chk({tag, "_cycle"}, cyc, 1);
        chk({tag, "_err"}, {31'd0, e}, 32'd1);
        chk({tag, "_rdata"}, rd, 32'd0);
        chk({tag, "_we"}, wec, 0);
    endtask

    initial begin
        int cyc, wec, acc, busy_low, we_ld, we_st;
        logic [31:0] rd; logic e;
        logic [7:0] sw_bytes [4];
        sw_bytes[0] = 8'h11; sw_bytes[1] = 8'h22; sw_bytes[2] = 8'h33; sw_bytes[3] = 8'h44;

        for (int k = 0; k < 65536; k++) ram[k] = 8'h00;
        ram[16'h0043] = 8'h5A;
        ram[16'hFFFC] = 8'hDE; ram[16'hFFFD] = 8'hAD;
        ram[16'hFFFE] = 8'hBE; ram[16'hFFFF] = 8'hEF;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        @(posedge clk); #1;

        // Store word: big-endian byte stream in cycles 1..4
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, cyc, rd, e, wec);
        chk("sw_cycle", cyc, 5);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_err", {31'd0, e}, 32'd0);
        chk("sw_we_count", wec, 4);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("sw_addr%0d", c), {16'd0, log_addr[c]}, 32'h10 + c - 1);
            chk($sformatf("sw_data%0d", c), {24'd0, log_wd[c]}, {24'd0, sw_bytes[c-1]});
            chk($sformatf("sw_we%0d", c), {31'd0, log_we[c]}, 32'd1);
        end

        // Load word back
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, cyc, rd, e, wec);
        chk("lw_cycle", cyc, 6);
        chk("lw_rdata", rd, 32'h11223344);
        chk("lw_we_count", wec, 0);
        for (int c = 1; c <= 4; c++)
            chk($sformatf("lw_addr%0d", c), {16'd0, log_addr[c]}, 32'h10 + c - 1);

        // Extension
        expect_ok("sb",  1'b1, 2'b00, 1'b0, 32'h20, 32'h000000F0, 2, 32'h0);
        expect_ok("lb",  1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 3, 32'hFFFFFFF0);
        expect_ok("lbu", 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 3, 32'h000000F0);
        expect_ok("sh",  1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 3, 32'h0);
        expect_ok("lh",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 4, 32'hFFFF8001);
        expect_ok("lhu", 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 4, 32'h00008001);
        expect_ok("lb_pos", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 3, 32'h00000022);

        // Top-of-memory word ends exactly at the last address
        run_req(1'b0, 2'b10, 1'b0, 32'hFFFC, 32'h0, cyc, rd, e, wec);
        chk("lw_top_rdata", rd, 32'hDEADBEEF);
        chk("lw_top_lastaddr", {16'd0, log_addr[4]}, 32'hFFFF);

        // Errors
        expect_err("err_lw_mis", 2'b10, 32'h0011);
        expect_err("err_lh_mis", 2'b01, 32'h0021);
        expect_err("err_size11", 2'b11, 32'h0000);
        expect_err("err_range",  2'b10, 32'h00010000);

        // Reset in the middle of a store word
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) rst = 1'b1;
            @(negedge clk);
            chk($sformatf("rst_mid_rv%0d", c), {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_rv4", {31'd0, resp_valid}, 32'd0);
        chk("rst_mid_we4", {31'd0, mem_we}, 32'd0);
        chk("rst_mid_ram40", {24'd0, ram[16'h40]}, 32'hAA);
        chk("rst_mid_ram42", {24'd0, ram[16'h42]}, 32'hCC);
        chk("rst_mid_ram43", {24'd0, ram[16'h43]}, 32'h5A);
        @(posedge clk); #1;
        expect_ok("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 6, 32'hAABBCC5A);

        // Reset wins over a simultaneous request
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h20;
        @(posedge clk); #1 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back: lw then sw with req_valid held high
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(negedge clk);
        log_busy[0] = busy; log_we[0] = mem_we; log_rv[0] = resp_valid;
        @(posedge clk); #1;
        req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
        acc = -1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            log_busy[c] = busy; log_we[c] = mem_we; log_rv[c] = resp_valid;
            if (req_ready && acc < 0) acc = c;
            @(posedge clk); #1;
            if (c == acc) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        busy_low = 0; we_ld = 0; we_st = 0;
        for (int c = 0; c <= 12; c++) begin
            if (!log_busy[c]) busy_low++;
            if (log_we[c] && c <= 7) we_ld++;
            if (log_we[c] && c >= 8 && c <= 11) we_st++;
        end
        $display("txn back-to-back lw/sw -> second accepted in cycle %0d", acc);
        chk("b2b_accept_cycle", acc, 7);
        chk("b2b_busy0", {31'd0, log_busy[0]}, 32'd0);
        chk("b2b_busy7", {31'd0, log_busy[7]}, 32'd0);
        chk("b2b_busy_low_count", busy_low, 2);
        chk("b2b_lw_resp6", {31'd0, log_rv[6]}, 32'd1);
        chk("b2b_sw_resp12", {31'd0, log_rv[12]}, 32'd1);
        chk("b2b_we_during_lw", we_ld, 0);
        chk("b2b_we_during_sw", we_st, 4);
        expect_ok("b2b_readback", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 6, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store sequencer for the Antares-R2 datapath. It sits directly upstream of the byte-wide data memory. It accepts one load or store per handshake from the MEM stage (lb/lbu/lh/lhu/lw/sb/sh/sw). Each access is serialised into 1, 2 or 4 byte transactions on an 8-bit synchronous RAM port, in big-endian order. It returns a sign- or zero-extended 32-bit result, or an error flag.

## Interface
- ADDR_WIDTH, 16: byte-address width of the data memory; legal addresses are 0 .. 2^ADDR_WIDTH-1.
- clk  input  1  system clock; all registers update on its rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  high in IDLE only; request accepted when req_valid && req_ready at a rising edge
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  extended load result; 0 for stores and errors; holds until the next response
- resp_err  output  1  qualified by resp_valid: misaligned, reserved size, or out of range
- busy  output  1  state != IDLE
- mem_addr  output  ADDR_WIDTH  byte address to RAM
- mem_we  output  1  byte write enable
- mem_wdata  output  8  byte to write
- mem_rdata  input  8  RAM read data, valid the cycle after its address was driven

## Operation
- States: IDLE, ACCESS, LAST, RESP.
- **IDLE** (on accept):
  - Latch write, size, unsigned, address low bits and wdata.
  - Set n = 1/2/4 for byte/half/word; clear index i.
  - Error check (request is an error if any holds):
    - size 11;
    - half with addr[0] != 0;
    - word with addr[1:0] != 0;
    - req_addr[31:ADDR_WIDTH] != 0.
  - Error → RESP with err = 1. Otherwise → ACCESS.
- **ACCESS**:
  - mem_addr = base + i (ADDR_WIDTH bits); mem_we = write.
  - mem_wdata = byte i of the n-byte quantity, MSB first:
    - word: [31:24], [23:16], [15:8], [7:0];
    - half: [15:8], [7:0];
    - byte: [7:0].
  - i increments each cycle.
  - At i == n-1: store → RESP; load → LAST.
- **Load capture**: in ACCESS with i ≥ 1, and in LAST, rbuf <= {rbuf[23:0], mem_rdata}.
- **RESP**:
  - resp_valid = 1 for exactly one cycle.
  - resp_rdata (loads), by size:
    - byte: {24{s&b[7]}, b};
    - half: {16{s&h[15]}, h};
    - word: rbuf.
    - s = !unsigned.
  - Next state is IDLE.
- mem_we = 0 in every state except ACCESS with write = 1.
- mem_addr holds its last value outside ACCESS.
- Aligned in-range accesses never wrap: a word at 2^ADDR_WIDTH-4 ends exactly at the top address.
- **Reset values**: state IDLE, req_ready 1, busy 0, resp_valid 0, resp_rdata 0, resp_err 0, mem_addr 0, mem_we 0, mem_wdata 0.

## Timing
- Cycle 0 is the cycle in which the request is accepted.
- ACCESS occupies cycles 1..n.
- resp_valid timing:
  - loads: cycle n+2 (byte 3, half 4, word 6);
  - stores: cycle n+1 (byte 2, half 3, word 5);
  - errors: cycle 1, with no RAM activity.
- The next request can be accepted in the cycle after RESP. Back-to-back throughput is one access per n+3 cycles for loads and n+2 for stores.
- req_valid while not IDLE is ignored. Request inputs are not sampled after acceptance.
- **Reset mid-operation**:
  - rst high in cycle k forces IDLE at cycle k+1.
  - A store byte driven in cycle k is still written, because the RAM samples at the same edge.
  - Remaining bytes are not written and no response is issued.
  - Partially written data is not rolled back.
- rst has priority over a simultaneous req_valid: the request is not accepted.

## Test plan
- **Store word:** sw 0x11223344 @0x0010 → mem_we high in cycles 1–4 with addr/data 0x10/0x11, 0x11/0x22, 0x12/0x33, 0x13/0x44. resp_valid in cycle 5 with err 0 and rdata 0.
- **Load word:** lw @0x0010 after the store → addresses 0x10–0x13 in cycles 1–4, mem_we 0 throughout. resp_valid in cycle 6 with rdata 0x11223344.
- **Extension:**
  - sb 0x000000F0 @0x20, then lb → 0xFFFFFFF0 (cycle 3); lbu → 0x000000F0.
  - sh 0x00008001 @0x22, then lh → 0xFFFF8001; lhu → 0x00008001.
- **Errors:** each of the following gives resp_valid + resp_err in cycle 1, rdata 0, mem_we never asserted:
  - lw @0x0011;
  - lh @0x0021;
  - size 11 @0x0000;
  - lw @0x00010000.
- **Reset mid-store:** sw 0xAABBCCDD @0x40 with rst high in cycle 3 → bytes 0x40–0x42 written, 0x43 unchanged, no resp_valid, req_ready 1 in cycle 4. A following lw @0x40 returns 0xAABBCC followed by the old byte.
- **Back-to-back:** req_valid held high with lw then sw → second request accepted in cycle 7, busy low only in cycles 0 and 7, no overlap of RAM transactions.
